// File: rtl/mov_seq_pkg.sv
// Shared types and constants for the movimiento sequencer: FSM states,
// peripheral register map, table geometry and the dwell register address.
package mov_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    DWELL,
    RD_T,
    RD_P,
    NEXT
  } state_t;

  localparam logic [3:0] ADDR_SS    = 4'h0;
  localparam logic [3:0] ADDR_RV1   = 4'h2;
  localparam logic [3:0] ADDR_RV2   = 4'h4;
  localparam logic [3:0] ADDR_RH1   = 4'h6;
  localparam logic [3:0] ADDR_RH2   = 4'h8;
  localparam logic [3:0] ADDR_THETA = 4'hA;
  localparam logic [3:0] ADDR_PHI   = 4'hC;

  localparam int unsigned N_FIELDS   = 5;
  localparam logic [4:0]  DWELL_ADDR = 5'd31;

  function automatic logic [3:0] field_addr(input logic [2:0] field);
    case (field)
      3'd0:    return ADDR_SS;
      3'd1:    return ADDR_RV1;
      3'd2:    return ADDR_RV2;
      3'd3:    return ADDR_RH1;
      3'd4:    return ADDR_RH2;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mov_seq_timer.sv
// Down-counting dwell timer: load captures the period, tick counts it down,
// expire flags the final cycle of the period (count of 1 or less).
module mov_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  always_comb begin
    expire = (cnt <= W'(1));
  end

endmodule

// File: rtl/movimiento_sequencer.sv
// Setpoint sequencer: writes five fields per step to the movement peripheral,
// dwells, then reads back theta/phi. Readback is enabled by MOV_SEQ_READBACK_EN.
module movimiento_sequencer
  import mov_seq_pkg::*;
#(
  parameter int N_STEPS = 4,
  parameter int DWELL_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        start,
  input  logic        abort,
  output logic        m_cs,
  output logic        m_wr,
  output logic        m_rd,
  output logic [3:0]  m_addr,
  output logic [15:0] m_d_out,
  input  logic [15:0] m_d_in,
  output logic        busy,
  output logic        done,
  output logic [2:0]  step_idx,
  output logic [1:0]  theta_q,
  output logic [1:0]  phi_q
);

  state_t state, state_nxt;

  logic [2:0]         wcnt;
  logic [15:0]        tbl [0:31];
  logic [4:0]         tbl_idx;
  logic [DWELL_W-1:0] dwell;
  logic [DWELL_W-1:0] dwell_eff;
  logic               tmr_load, tmr_tick, tmr_expire;
  logic               done_set;
  logic               last_step;
  logic               cfg_hit_tbl;
  logic               unused_din;

  assign tbl_idx     = 5'(int'(step_idx) * N_FIELDS + int'(wcnt));
  assign last_step   = (step_idx == 3'(N_STEPS - 1));
  assign cfg_hit_tbl = (cfg_addr < 5'(N_FIELDS * N_STEPS));
  assign dwell_eff   = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign unused_din  = ^m_d_in;

  mov_seq_timer #(
    .W(DWELL_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(dwell_eff),
    .tick    (tmr_tick),
    .expire  (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wcnt     <= '0;
      step_idx <= '0;
      done     <= 1'b0;
      theta_q  <= '0;
      phi_q    <= '0;
      dwell    <= DWELL_W'(1);
      for (int unsigned i = 0; i < 32; i++) tbl[i] <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_set;
      wcnt  <= (state == WRITE && state_nxt == WRITE) ? wcnt + 3'd1 : '0;

      if (state == IDLE && start && !abort) begin
        step_idx <= '0;
      end else if (state == NEXT && !abort && !last_step) begin
        step_idx <= step_idx + 3'd1;
      end

      if (state == IDLE && cfg_we) begin
        if (cfg_hit_tbl) begin
          tbl[cfg_addr] <= cfg_data;
        end else if (cfg_addr == DWELL_ADDR) begin
          dwell <= DWELL_W'(cfg_data);
        end
      end

`ifdef MOV_SEQ_READBACK_EN
      if (state == RD_T && !abort) theta_q <= m_d_in[1:0];
      if (state == RD_P && !abort) phi_q   <= m_d_in[1:0];
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    m_cs      = 1'b0;
    m_wr      = 1'b0;
    m_rd      = 1'b0;
    m_addr    = '0;
    m_d_out   = '0;
    tmr_load  = 1'b0;
    tmr_tick  = 1'b0;
    done_set  = 1'b0;
    busy      = (state != IDLE);

    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = WRITE;
      end
      WRITE: begin
        m_cs    = 1'b1;
        m_wr    = 1'b1;
        m_addr  = field_addr(wcnt);
        m_d_out = tbl[tbl_idx];
        // Timer is loaded on the last write so DWELL starts counting at once.
        if (wcnt == 3'(N_FIELDS - 1)) begin
          state_nxt = DWELL;
          tmr_load  = 1'b1;
        end
      end
      DWELL: begin
        tmr_tick = 1'b1;
`ifdef MOV_SEQ_READBACK_EN
        if (tmr_expire) state_nxt = RD_T;
`else
        if (tmr_expire) state_nxt = NEXT;
`endif
      end
`ifdef MOV_SEQ_READBACK_EN
      RD_T: begin
        m_cs      = 1'b1;
        m_rd      = 1'b1;
        m_addr    = ADDR_THETA;
        state_nxt = RD_P;
      end
      RD_P: begin
        m_cs      = 1'b1;
        m_rd      = 1'b1;
        m_addr    = ADDR_PHI;
        state_nxt = NEXT;
      end
`endif
      NEXT: begin
        if (last_step) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end else begin
          state_nxt = WRITE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      done_set  = 1'b0;
    end
  end

endmodule

// File: tb/tb_movimiento_sequencer.sv
// Self-checking bench for movimiento_sequencer; builds the expected bus trace
// per sequence from the table/dwell contents and compares every cycle.
module tb_movimiento_sequencer;

  localparam int NS = 4;
  localparam int DW = 16;
`ifdef MOV_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, cfg_we, start, abort;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        m_cs, m_wr, m_rd, busy, done;
  logic [3:0]  m_addr;
  logic [15:0] m_d_out, m_d_in;
  logic [2:0]  step_idx;
  logic [1:0]  theta_q, phi_q;

  always #5 clk = ~clk;

  movimiento_sequencer #(.N_STEPS(NS), .DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .abort(abort), .m_cs(m_cs), .m_wr(m_wr), .m_rd(m_rd),
    .m_addr(m_addr), .m_d_out(m_d_out), .m_d_in(m_d_in), .busy(busy), .done(done),
    .step_idx(step_idx), .theta_q(theta_q), .phi_q(phi_q)
  );

  // Peripheral model: theta at 0xA, phi at 0xC, random upper bits.
  logic [1:0]  p_theta, p_phi;
  logic [13:0] hi_bits;
  assign m_d_in = (m_addr == 4'hA) ? {hi_bits, p_theta} :
                  (m_addr == 4'hC) ? {hi_bits, p_phi} : 16'hDEAD;

  typedef struct packed {
    logic        cs, wr, rd;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        bsy, dn;
    logic [2:0]  step;
  } obs_t;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] mtbl [0:NS-1][0:4];
  int unsigned mdwell;
  logic [1:0]  exp_theta, exp_phi;

  function automatic obs_t mk(logic cs, logic wr, logic rd, logic [3:0] a,
                              logic [15:0] d, logic b, logic dn, logic [2:0] s);
    obs_t o;
    o.cs = cs; o.wr = wr; o.rd = rd; o.addr = a; o.data = d;
    o.bsy = b; o.dn = dn; o.step = s;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk(m_cs, m_wr, m_rd, m_addr, m_d_out, busy, done, step_idx);
  endfunction

  function automatic int unsigned eff(int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int unsigned step_len();
    return 5 + eff(mdwell) + (RB ? 2 : 0) + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_nostep(input string tag);
    obs_t o;
    o = observe();
    o.step = '0;
    check(tag, 32'(o), 32'(mk(0, 0, 0, '0, '0, 0, 0, '0)));
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (int'(a) < 5 * NS) mtbl[int'(a) / 5][int'(a) % 5] = d;
    else if (a == 5'd31) mdwell = d;
  endtask

  task automatic load_random_table(input int unsigned dmax);
    for (int unsigned s = 0; s < NS; s++)
      for (int unsigned f = 0; f < 5; f++)
        cfg_write(5'(s * 5 + f), 16'($urandom));
    cfg_write(5'd31, 16'($urandom_range(0, dmax)));
  endtask

  task automatic run_seq(input int abort_at, input int inject_at);
    obs_t q[$];
    for (int unsigned s = 0; s < NS; s++) begin
      for (int unsigned f = 0; f < 5; f++)
        q.push_back(mk(1, 1, 0, 4'(2 * f), mtbl[s][f], 1, 0, 3'(s)));
      for (int unsigned d = 0; d < eff(mdwell); d++)
        q.push_back(mk(0, 0, 0, '0, '0, 1, 0, 3'(s)));
      if (RB) begin
        q.push_back(mk(1, 0, 1, 4'hA, '0, 1, 0, 3'(s)));
        q.push_back(mk(1, 0, 1, 4'hC, '0, 1, 0, 3'(s)));
      end
      q.push_back(mk(0, 0, 0, '0, '0, 1, 0, 3'(s)));
    end
    q.push_back(mk(0, 0, 0, '0, '0, 0, 1, 3'(NS - 1)));
    q.push_back(mk(0, 0, 0, '0, '0, 0, 0, 3'(NS - 1)));

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      check($sformatf("seq_c%0d", i), 32'(observe()), 32'(q[i]));
      if (q[i].rd && i != abort_at) begin
        if (q[i].addr == 4'hA) exp_theta = p_theta;
        else exp_phi = p_phi;
      end
      if (i == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_nostep("abort_idle");
        @(negedge clk);
        check_idle_nostep("abort_no_done");
        break;
      end
      if (i == inject_at) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = ~mtbl[0][0];
      end
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
    end
    check("theta_phi", 32'({theta_q, phi_q}), 32'({exp_theta, exp_phi}));
  endtask

  task automatic measure_latency();
    int cnt;
    cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", 32'(cnt), 32'(NS * step_len()));
    if (RB) begin
      exp_theta = p_theta;
      exp_phi   = p_phi;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; abort = 1'b0;
    p_theta = 2'd2; p_phi = 2'd1; hi_bits = 14'($urandom);
    for (int s = 0; s < NS; s++) for (int f = 0; f < 5; f++) mtbl[s][f] = '0;
    mdwell = 1; exp_theta = '0; exp_phi = '0;

    repeat (3) @(negedge clk);
    check("reset_bus", 32'(observe()), 32'(mk(0, 0, 0, '0, '0, 0, 0, '0)));
    check("reset_tp", 32'({theta_q, phi_q}), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Reset-default table (all zero) with dwell 1.
    run_seq(-1, -1);

    // Directed table: step0 = {1,0x10,0x20,0x30,0x40}, dwell 3.
    cfg_write(5'd0, 16'h0001); cfg_write(5'd1, 16'h0010); cfg_write(5'd2, 16'h0020);
    cfg_write(5'd3, 16'h0030); cfg_write(5'd4, 16'h0040);
    for (int unsigned a = 5; a < 5 * NS; a++) cfg_write(5'(a), 16'($urandom));
    cfg_write(5'd31, 16'd3);
    run_seq(-1, -1);
    measure_latency();

    // dwell = 0 behaves as 1.
    cfg_write(5'd31, 16'd0);
    run_seq(-1, -1);
    measure_latency();

    // Unmapped addresses ignored; cfg_we and start while busy ignored.
    cfg_write(5'd25, 16'hBEEF);
    cfg_write(5'(5 * NS), 16'hCAFE);
    cfg_write(5'd31, 16'd2);
    p_theta = 2'd3; p_phi = 2'd0;
    run_seq(-1, 3);
    run_seq(-1, -1);

    // Abort during step 2 WRITE, then restart from step 0.
    p_theta = 2'd1; p_phi = 2'd2;
    run_seq(2 * int'(step_len()) + 2, -1);
    run_seq(-1, -1);

    // abort wins over start in IDLE.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_idle_nostep("start_abort_idle");

    for (int k = 0; k < 4; k++) begin
      load_random_table(5);
      p_theta = 2'($urandom); p_phi = 2'($urandom); hi_bits = 14'($urandom);
      if (k % 2 == 1) run_seq(int'($urandom_range(0, NS * step_len() - 1)), -1);
      else run_seq(-1, int'($urandom_range(0, NS * step_len() - 1)));
    end

    // Reset mid-sequence wins over abort/start and clears table/dwell/readback.
    p_theta = 2'd3; p_phi = 2'd3;
    load_random_table(3);
    measure_latency();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1; abort = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; abort = 1'b0; start = 1'b0;
    check("midrst_bus", 32'(observe()), 32'(mk(0, 0, 0, '0, '0, 0, 0, '0)));
    check("midrst_tp", 32'({theta_q, phi_q}), 32'(0));
    for (int s = 0; s < NS; s++) for (int f = 0; f < 5; f++) mtbl[s][f] = '0;
    mdwell = 1; exp_theta = '0; exp_phi = '0;
    p_theta = 2'd2; p_phi = 2'd1;
    run_seq(-1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/movimiento_sequencer.md
MOVIMIENTO_SEQUENCER -- requirements
Module: movimiento_sequencer

Interface
REQ-001 Parameter N_STEPS, default 4, number of setpoint steps in the table; legal range 1..6.
REQ-002 Parameter DWELL_W, default 16, width of the dwell counter and of the dwell register.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cfg_we  in  1  table/config write strobe.
REQ-006 cfg_addr  in  5  0..5*N_STEPS-1 = step*5+field, fields 0..4 = SS,RV1,RV2,RH1,RH2; 31 = dwell register.
REQ-007 cfg_data  in  16  config write data.
REQ-008 start  in  1  begin sequence at step 0.
REQ-009 abort  in  1  terminate sequence.
REQ-010 m_cs, m_wr, m_rd  out  1 each  peripheral bus strobes toward the movement peripheral.
REQ-011 m_addr  out  4  peripheral register address.
REQ-012 m_d_out  out  16  peripheral write data.
REQ-013 m_d_in  in  16  peripheral read data.
REQ-014 busy  out  1  sequence in progress.
REQ-015 done  out  1  one-cycle pulse at sequence completion.
REQ-016 step_idx  out  3  current step index.
REQ-017 theta_q, phi_q  out  2 each  last captured s_out_theta and s_out_phi.

Function
REQ-018 FSM states: IDLE, WRITE, DWELL, RD_T, RD_P, NEXT; the state flow shall be IDLE->WRITE->DWELL->RD_T->RD_P->NEXT->(WRITE | IDLE).
REQ-019 cfg_we in IDLE shall write the table entry or dwell register at the next posedge; cfg_we outside IDLE, and at unmapped addresses, shall be ignored.
REQ-020 start in IDLE shall set busy and step_idx=0 and enter WRITE next cycle; start while busy shall be ignored.
REQ-021 WRITE: 5 consecutive cycles with m_cs=1, m_wr=1, m_rd=0, m_addr=0x0,0x2,0x4,0x6,0x8 and m_d_out = the corresponding field of the current step.
REQ-022 DWELL shall last max(dwell,1) cycles with all strobes low; dwell reset value shall be 1.
REQ-023 RD_T: one cycle with m_cs=1, m_rd=1, m_addr=0xA; theta_q <= m_d_in[1:0] at the posedge ending RD_T.
REQ-024 RD_P: same with m_addr=0xC; phi_q <= m_d_in[1:0] at the posedge ending RD_P.
REQ-025 NEXT: if step_idx==N_STEPS-1, go to IDLE, clear busy and pulse done for exactly that cycle; otherwise increment step_idx and go to WRITE.
REQ-026 Per-step latency shall be 7+max(dwell,1) cycles plus 1 NEXT cycle.
REQ-027 abort in any non-IDLE state shall return to IDLE at the next posedge: strobes low, busy=0, no done pulse, theta_q/phi_q retained; abort has priority over start.
REQ-028 In IDLE, m_cs, m_wr and m_rd shall be 0, m_addr=0 and m_d_out=0.

Reset
REQ-029 rst shall force IDLE, busy=0, done=0, step_idx=0, theta_q=0, phi_q=0, all m_* outputs 0 and dwell=1; table contents shall be cleared to 0.
REQ-030 rst asserted mid-sequence shall take effect at the next posedge, regardless of abort or start.

Configuration
REQ-031 Macro MOV_SEQ_READBACK_EN: when defined, RD_T/RD_P shall run as specified.
REQ-032 When MOV_SEQ_READBACK_EN is undefined, DWELL shall go directly to NEXT, theta_q and phi_q shall stay 0, and m_rd shall never assert.

Structure
REQ-033 Package mov_seq_pkg shall hold the state enum, the peripheral address constants (0x0,0x2,0x4,0x6,0x8,0xA,0xC), the field count of 5 and the dwell address of 31.
REQ-034 The dwell counter shall be one sub-module, mov_seq_timer (load, tick, expire).

Verification
REQ-035 rst, then start with N_STEPS=1, dwell=3, table {1,0x10,0x20,0x30,0x40} -> 5 write cycles at addresses 0,2,4,6,8 with that data, 3 idle cycles, reads at 0xA/0xC, done pulse 12 cycles after start.
REQ-036 Peripheral model returns theta=2 and phi=1 -> theta_q=2 and phi_q=1 after the sequence; step_idx sweeps 0..3 when N_STEPS=4.
REQ-037 dwell=0 -> DWELL lasts exactly 1 cycle.
REQ-038 abort during step 2 WRITE -> IDLE next cycle, no done pulse, strobes low; a following start restarts at step 0.
REQ-039 cfg_we while busy, or to address 25 -> table unchanged; start while busy -> no restart.
REQ-040 Build without MOV_SEQ_READBACK_EN -> m_rd never asserts, per-step latency is 6+dwell cycles, done still pulses.
